// File: rtl/dcache_miss_ctrl_pkg.sv
// Shared types, defaults and width helpers for the data-cache miss controller.
package dcache_miss_ctrl_pkg;
  localparam int DC_ADDR_W = 32;
  localparam int DC_SET_W  = 2;
  localparam int DC_WAY_W  = 2;
  localparam int DC_OFF_W  = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_VICTIM,
    S_EVICT,
    S_WB_WAIT,
    S_FILL_REQ,
    S_FILL_WAIT,
    S_UPDATE
  } miss_state_e;

  function automatic int dc_tag_w(input int addr_w, input int set_w, input int off_w);
    return addr_w - set_w - off_w;
  endfunction
endpackage

// File: rtl/dcache_lru_upd_buf.sv
// LRU update port arbiter: controller update wins, a colliding hit waits one
// cycle in a single-entry buffer, hits arriving while it is occupied are dropped.
module dcache_lru_upd_buf
  import dcache_miss_ctrl_pkg::*;
#(
  parameter int SET_W = DC_SET_W,
  parameter int WAY_W = DC_WAY_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ctrl_upd,
  input  logic [SET_W-1:0] ctrl_set,
  input  logic [WAY_W-1:0] ctrl_way,
  input  logic             hit_valid,
  input  logic [SET_W-1:0] hit_set,
  input  logic [WAY_W-1:0] hit_way,
  output logic             upd_req,
  output logic [SET_W-1:0] upd_set,
  output logic [WAY_W-1:0] upd_way
);
  logic             pend_vld_q, pend_vld_d;
  logic [SET_W-1:0] pend_set_q, pend_set_d;
  logic [WAY_W-1:0] pend_way_q, pend_way_d;

  always_comb begin
    pend_vld_d = pend_vld_q;
    pend_set_d = pend_set_q;
    pend_way_d = pend_way_q;
    upd_req    = 1'b0;
    upd_set    = '0;
    upd_way    = '0;
    if (ctrl_upd) begin
      upd_req = 1'b1;
      upd_set = ctrl_set;
      upd_way = ctrl_way;
      if (hit_valid && !pend_vld_q) begin
        pend_vld_d = 1'b1;
        pend_set_d = hit_set;
        pend_way_d = hit_way;
      end
    end else if (pend_vld_q) begin
      // Older hint drains first; a hit in this same cycle is lost.
      upd_req    = 1'b1;
      upd_set    = pend_set_q;
      upd_way    = pend_way_q;
      pend_vld_d = 1'b0;
    end else if (hit_valid) begin
      upd_req = 1'b1;
      upd_set = hit_set;
      upd_way = hit_way;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_vld_q <= 1'b0;
      pend_set_q <= '0;
      pend_way_q <= '0;
    end else begin
      pend_vld_q <= pend_vld_d;
      pend_set_q <= pend_set_d;
      pend_way_q <= pend_way_d;
    end
  end
endmodule

// File: rtl/dcache_miss_ctrl.sv
// Data-cache miss controller: victim selection, optional write-back, line fill
// and LRU update, one miss at a time.
module dcache_miss_ctrl
  import dcache_miss_ctrl_pkg::*;
#(
  parameter  int ADDR_W = DC_ADDR_W,
  parameter  int SET_W  = DC_SET_W,
  parameter  int WAY_W  = DC_WAY_W,
  parameter  int OFF_W  = DC_OFF_W,
  localparam int TAG_W  = dc_tag_w(ADDR_W, SET_W, OFF_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              miss_req,
  input  logic [ADDR_W-1:0] miss_addr,
  output logic              miss_ack,
  input  logic              hit_valid,
  input  logic [SET_W-1:0]  hit_set,
  input  logic [WAY_W-1:0]  hit_way,
  output logic              victim_req,
  output logic [SET_W-1:0]  victim_set,
  input  logic [WAY_W-1:0]  victim_way,
  output logic              update_req,
  output logic [SET_W-1:0]  update_set,
  output logic [WAY_W-1:0]  update_way,
  input  logic              victim_dirty,
  input  logic [TAG_W-1:0]  victim_tag,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rsp_valid,
  output logic              fill_valid,
  output logic [SET_W-1:0]  fill_set,
  output logic [WAY_W-1:0]  fill_way,
  output logic              busy
);
  localparam int LINE_W = ADDR_W - OFF_W;

  miss_state_e       state_q, state_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [WAY_W-1:0]  way_q, way_d;
  logic [SET_W-1:0]  lat_set;
  logic [TAG_W-1:0]  lat_tag;
  logic              ack_c, vic_c, mreq_c, mwe_c, fill_c, ctrl_upd;
  logic [ADDR_W-1:0] maddr_c;
  logic              upd_req_c;
  logic [SET_W-1:0]  upd_set_c;
  logic [WAY_W-1:0]  upd_way_c;
  logic              unused_off;

  assign lat_set    = line_q[SET_W-1:0];
  assign lat_tag    = line_q[LINE_W-1:SET_W];
  assign unused_off = ^miss_addr[OFF_W-1:0];

  always_comb begin
    state_d  = state_q;
    line_d   = line_q;
    way_d    = way_q;
    ack_c    = 1'b0;
    vic_c    = 1'b0;
    mreq_c   = 1'b0;
    mwe_c    = 1'b0;
    maddr_c  = '0;
    fill_c   = 1'b0;
    ctrl_upd = 1'b0;
    case (state_q)
      S_IDLE: if (miss_req) begin
        ack_c   = 1'b1;
        line_d  = miss_addr[ADDR_W-1:OFF_W];
        state_d = S_VICTIM;
      end
      S_VICTIM: begin
        vic_c   = 1'b1;
        way_d   = victim_way;
        state_d = S_EVICT;
      end
      S_EVICT: if (victim_dirty) begin
        mreq_c  = 1'b1;
        mwe_c   = 1'b1;
        maddr_c = {victim_tag, lat_set, {OFF_W{1'b0}}};
        if (mem_gnt) state_d = S_WB_WAIT;
      end else begin
        state_d = S_FILL_REQ;
      end
      S_WB_WAIT: if (mem_rsp_valid) state_d = S_FILL_REQ;
      S_FILL_REQ: begin
        mreq_c  = 1'b1;
        maddr_c = {lat_tag, lat_set, {OFF_W{1'b0}}};
        if (mem_gnt) state_d = S_FILL_WAIT;
      end
      S_FILL_WAIT: if (mem_rsp_valid) begin
        fill_c  = 1'b1;
        state_d = S_UPDATE;
      end
      S_UPDATE: begin
        ctrl_upd = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      line_q  <= '0;
      way_q   <= '0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      way_q   <= way_d;
    end
  end

  dcache_lru_upd_buf #(.SET_W(SET_W), .WAY_W(WAY_W)) u_upd_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .ctrl_upd  (ctrl_upd),
    .ctrl_set  (lat_set),
    .ctrl_way  (way_q),
    .hit_valid (hit_valid),
    .hit_set   (hit_set),
    .hit_way   (hit_way),
    .upd_req   (upd_req_c),
    .upd_set   (upd_set_c),
    .upd_way   (upd_way_c)
  );

  // Every output is forced low while reset is held, including pass-through hits.
  assign miss_ack   = rst_n & ack_c;
  assign victim_req = rst_n & vic_c;
  assign victim_set = victim_req ? lat_set : '0;
  assign mem_req    = rst_n & mreq_c;
  assign mem_we     = rst_n & mwe_c;
  assign mem_addr   = rst_n ? maddr_c : '0;
  assign fill_valid = rst_n & fill_c;
  assign fill_set   = fill_valid ? lat_set : '0;
  assign fill_way   = fill_valid ? way_q : '0;
  assign update_req = rst_n & upd_req_c;
  assign update_set = rst_n ? upd_set_c : '0;
  assign update_way = rst_n ? upd_way_c : '0;
  assign busy       = rst_n & (state_q != S_IDLE);
endmodule
